// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
package udp_tx_pkg;

  typedef enum logic [1:0] {StFill, StHdr, StSend} state_e;

  localparam int unsigned UDP_HDR_LEN     = 8;
  localparam int unsigned MAX_UDP_PAYLOAD = 1472;

  // Bits needed to hold 0..max_val inclusive (never less than one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/udp_tx_pkt_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port (1-cycle latency).
module udp_tx_pkt_ram #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Read data holds while rd_en is low; the output stage relies on this when stalled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers a byte stream into UDP datagrams, flushed when full or after an idle timeout.
// Optional statistics counters are enabled by defining UDP_TX_STATS_EN.
module udp_tx_packetizer
  import udp_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 1024,
  parameter int unsigned TIMEOUT  = 12500,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] local_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
`ifdef UDP_TX_STATS_EN
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_bytes,
`endif
  output logic        busy
);

  localparam int unsigned CW = cnt_width(MAX_LEN);
  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] MaxCnt     = CW'(MAX_LEN);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] len_q, len_d;
  logic [31:0]   dip_q, dip_d;
  logic [15:0]   dport_q, dport_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          pend_last_q, pend_last_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          wr_en, rd_en, load;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ram_rdata;

  udp_tx_pkt_ram #(
    .DEPTH (MAX_LEN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    timer_d       = timer_q;
    len_d         = len_q;
    dip_d         = dip_q;
    dport_d       = dport_q;
    rd_ptr_d      = rd_ptr_q;
    rd_pend_d     = rd_pend_q;
    pend_last_d   = pend_last_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = rd_ptr_q[AW-1:0];
    load          = 1'b0;
    s_axis_tready = 1'b0;

    unique case (state_q)
      StFill: begin
        s_axis_tready = (count_q != MaxCnt);
        if (s_axis_tvalid && s_axis_tready) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          timer_d = '0;
        end else if (count_q != '0 && timer_q != TimeoutVal) begin
          timer_d = timer_q + TW'(1);
        end
        // A byte accepted alongside a timeout flush is included in the datagram.
        if (count_q == MaxCnt || (TIMEOUT != 0 && count_q != '0 && timer_q == TimeoutVal)) begin
          state_d = StHdr;
          len_d   = count_d;
          dip_d   = dest_ip;
          dport_d = dest_port;
        end
      end
      StHdr: begin
        // Prefetch byte 0 during the header handshake so data follows one cycle later.
        if (m_udp_hdr_ready) begin
          rd_en       = 1'b1;
          rd_addr     = '0;
          rd_ptr_d    = CW'(1);
          rd_pend_d   = 1'b1;
          pend_last_d = (len_q == CW'(1));
          state_d     = StSend;
        end
      end
      StSend: begin
        load = rd_pend_q && (!out_valid_q || m_udp_payload_axis_tready);
        if (out_valid_q && m_udp_payload_axis_tready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = StFill;
            count_d = '0;
            timer_d = '0;
          end
        end
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = ram_rdata;
          out_last_d  = pend_last_q;
          rd_pend_d   = 1'b0;
        end
        if ((!rd_pend_q || load) && rd_ptr_q != len_q) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + CW'(1);
          rd_pend_d   = 1'b1;
          pend_last_d = (rd_ptr_q == len_q - CW'(1));
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      count_q     <= '0;
      timer_q     <= '0;
      len_q       <= '0;
      dip_q       <= '0;
      dport_q     <= '0;
      rd_ptr_q    <= '0;
      rd_pend_q   <= 1'b0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      dip_q       <= dip_d;
      dport_q     <= dport_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_pend_q   <= rd_pend_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy                      = (state_q != StFill);
  assign m_udp_hdr_valid           = (state_q == StHdr);
  assign m_udp_ip_dscp             = '0;
  assign m_udp_ip_ecn              = '0;
  assign m_udp_ip_ttl              = TTL;
  assign m_udp_ip_source_ip        = local_ip;
  assign m_udp_ip_dest_ip          = dip_q;
  assign m_udp_source_port         = SRC_PORT;
  assign m_udp_dest_port           = dport_q;
  assign m_udp_length              = 16'(len_q) + 16'(UDP_HDR_LEN);
  assign m_udp_checksum            = '0;
  assign m_udp_payload_axis_tdata  = out_data_q;
  assign m_udp_payload_axis_tvalid = out_valid_q;
  assign m_udp_payload_axis_tlast  = out_valid_q && out_last_q;
  assign m_udp_payload_axis_tuser  = 1'b0;

`ifdef UDP_TX_STATS_EN
  logic [31:0] stat_pkts_q, stat_bytes_q;
  logic        pay_hs;

  assign pay_hs = out_valid_q && m_udp_payload_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_bytes_q <= '0;
    end else if (pay_hs) begin
      stat_bytes_q <= stat_bytes_q + 32'd1;
      if (out_last_q) stat_pkts_q <= stat_pkts_q + 32'd1;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_bytes = stat_bytes_q;
`endif

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer with input-to-output byte and header scoreboards.
module tb_udp_tx_packetizer;

  localparam int unsigned MaxLen  = 1024;
  localparam int unsigned Timeout = 100;
  localparam logic [31:0] LocalIp = 32'hC0A8_0001;
  localparam logic [31:0] DestIp  = 32'hC0A8_0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] local_ip = LocalIp;
  logic [31:0] dest_ip = DestIp;
  logic [15:0] dest_port = 16'd5001;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready = 1'b1;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip;
  logic [31:0] m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_checksum;
  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid;
  logic        m_udp_payload_axis_tready = 1'b1;
  logic        m_udp_payload_axis_tlast;
  logic        m_udp_payload_axis_tuser;
  logic        busy;
`ifdef UDP_TX_STATS_EN
  logic [31:0] stat_pkts;
  logic [31:0] stat_bytes;
`endif

  udp_tx_packetizer #(
    .MAX_LEN  (MaxLen),
    .TIMEOUT  (Timeout),
    .SRC_PORT (16'd5000),
    .TTL      (8'd64)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_axis_tdata              (s_axis_tdata),
    .s_axis_tvalid             (s_axis_tvalid),
    .s_axis_tready             (s_axis_tready),
    .local_ip                  (local_ip),
    .dest_ip                   (dest_ip),
    .dest_port                 (dest_port),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_ip_dscp             (m_udp_ip_dscp),
    .m_udp_ip_ecn              (m_udp_ip_ecn),
    .m_udp_ip_ttl              (m_udp_ip_ttl),
    .m_udp_ip_source_ip        (m_udp_ip_source_ip),
    .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
    .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
    .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
    .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
    .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
`ifdef UDP_TX_STATS_EN
    .stat_pkts                 (stat_pkts),
    .stat_bytes                (stat_bytes),
`endif
    .busy                      (busy)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int in_seq = 0;
  bit rand_mode = 1'b0;

  logic [7:0] exp_bytes [$];
  int         exp_len [$];
  int         exp_dport [$];

  int          cur_len = 0;
  int          out_idx = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          hdr_hold = 1'b0;
  bit          pay_hold = 1'b0;
  logic [15:0] snap_len, snap_dport;
  logic [31:0] snap_dip;
  logic [7:0]  snap_data;
  logic        snap_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_hdr(input int len, input int dport);
    exp_len.push_back(len);
    exp_dport.push_back(dport);
  endtask

  task automatic send_bytes(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = in_seq[7:0];
      s_axis_tvalid = 1'b1;
      guard = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        guard++;
        if (guard > 4000) break;
      end
      if (guard > 4000) begin
        check("send_wait", guard, 0);
        break;
      end
      @(posedge clk); #1;
      in_seq++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || exp_len.size() != 0 || exp_bytes.size() != 0) && guard < 6000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_wait", guard < 6000, 1);
  endtask

  // Output-side scoreboard, sampled between active edges.
  always @(negedge clk) begin
    if (rst) begin
      out_idx  = 0;
      hdr_hold = 1'b0;
      pay_hold = 1'b0;
    end else begin
      if (busy) check("in_rdy_busy", s_axis_tready, 0);
      if (s_axis_tvalid && s_axis_tready) exp_bytes.push_back(s_axis_tdata);

      if (hdr_hold) begin
        check("hdr_hold_valid", m_udp_hdr_valid, 1);
        check("hdr_hold_len", m_udp_length, snap_len);
        check("hdr_hold_dport", m_udp_dest_port, snap_dport);
        check("hdr_hold_dip", m_udp_ip_dest_ip, snap_dip);
      end
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        if (exp_len.size() == 0) begin
          check("hdr_unexpected", exp_len.size(), 1);
        end else begin
          check("hdr_len", m_udp_length, exp_len.pop_front());
          check("hdr_dport", m_udp_dest_port, exp_dport.pop_front());
          check("hdr_dip", m_udp_ip_dest_ip, DestIp);
          check("hdr_sip", m_udp_ip_source_ip, LocalIp);
          check("hdr_sport", m_udp_source_port, 16'd5000);
          check("hdr_ttl", m_udp_ip_ttl, 8'd64);
          check("hdr_zero", {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_checksum}, 0);
        end
        cur_len  = int'(m_udp_length) - 8;
        out_idx  = 0;
        hdr_hold = 1'b0;
      end else if (m_udp_hdr_valid) begin
        if (!hdr_hold) begin
          snap_len   = m_udp_length;
          snap_dport = m_udp_dest_port;
          snap_dip   = m_udp_ip_dest_ip;
        end
        hdr_hold = 1'b1;
      end else begin
        hdr_hold = 1'b0;
      end

      if (pay_hold) begin
        check("pay_hold_valid", m_udp_payload_axis_tvalid, 1);
        check("pay_hold_data", m_udp_payload_axis_tdata, snap_data);
        check("pay_hold_last", m_udp_payload_axis_tlast, snap_last);
      end
      if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) begin
        if (exp_bytes.size() == 0) check("pay_unexpected", exp_bytes.size(), 1);
        else check("pay_data", m_udp_payload_axis_tdata, exp_bytes.pop_front());
        check("pay_last", m_udp_payload_axis_tlast, out_idx == cur_len - 1);
        if (out_idx == 0) first_cyc = cyc;
        if (m_udp_payload_axis_tlast) begin
          last_cyc = cyc;
          out_idx  = 0;
        end else begin
          out_idx++;
        end
        pay_hold = 1'b0;
      end else if (m_udp_payload_axis_tvalid) begin
        if (!pay_hold) begin
          snap_data = m_udp_payload_axis_tdata;
          snap_last = m_udp_payload_axis_tlast;
        end
        pay_hold = 1'b1;
      end else begin
        pay_hold = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      m_udp_payload_axis_tready = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  initial begin
    int g;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", s_axis_tready, 1);
    check("rst_hdr_valid", m_udp_hdr_valid, 0);
    check("rst_pay_valid", m_udp_payload_axis_tvalid, 0);
    check("rst_tlast", m_udp_payload_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_dport", m_udp_dest_port, 0);
    check("rst_dip", m_udp_ip_dest_ip, 0);
    rst = 1'b0;

    // Full datagram, back-to-back output.
    push_hdr(MaxLen + 8, 5001);
    send_bytes(MaxLen);
    wait_idle();
    check("t1_no_gaps", last_cyc - first_cyc, MaxLen - 1);

    // Partial datagram flushed by the idle timeout.
    push_hdr(18, 5001);
    send_bytes(10);
    g = 0;
    while (!m_udp_hdr_valid && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("t2_latency", g, Timeout + 1);
    wait_idle();

    // Header back-pressure, then random payload back-pressure.
    m_udp_hdr_ready = 1'b0;
    push_hdr(28, 5001);
    send_bytes(20);
    g = 0;
    while (!m_udp_hdr_valid && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("t3_hdr_seen", m_udp_hdr_valid, 1);
    repeat (50) @(posedge clk);
    #1;
    rand_mode = 1'b1;
    m_udp_hdr_ready = 1'b1;
    wait_idle();
    rand_mode = 1'b0;

    // Long stream split across datagram boundaries.
    push_hdr(MaxLen + 8, 5001);
    push_hdr(MaxLen + 8, 5001);
    push_hdr(2500 - 2 * MaxLen + 8, 5001);
    send_bytes(2500);
    wait_idle();

    // Reset in the middle of a datagram's payload.
    push_hdr(408, 5001);
    send_bytes(400);
    g = 0;
    while (out_idx < 300 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check("t5_reach_300", out_idx, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_hdr_valid", m_udp_hdr_valid, 0);
    check("t5_pay_valid", m_udp_payload_axis_tvalid, 0);
    check("t5_in_rdy", s_axis_tready, 1);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    exp_dport.delete();
    push_hdr(13, 5001);
    send_bytes(5);
    wait_idle();

    // Destination port change while a datagram is in flight.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_hdr(38, 5001);
    send_bytes(30);
    g = 0;
    while (!(busy && !m_udp_hdr_valid) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("t6_in_send", busy, 1);
    dest_port = 16'd6000;
    wait_idle();
    push_hdr(15, 6000);
    send_bytes(7);
    wait_idle();
`ifdef UDP_TX_STATS_EN
    check("stat_pkts", stat_pkts, 2);
    check("stat_bytes", stat_bytes, 37);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
